twi_target_receiver: RTL

TWI_TARGET_RECEIVER -- requirements
Module: twi_target_receiver

---
 rtl/twi_pkg.sv | 17 +
 rtl/twi_sync_edge.sv | 31 +++
 rtl/twi_target_receiver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/twi_pkg.sv
// Shared TWI target definitions: FSM state encoding and SDA drive levels.
// ACK means pulling SDA low, so sda_oe is high for ACK.
package twi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } twi_state_e;

    localparam logic OE_ACK  = 1'b1;
    localparam logic OE_NACK = 1'b0;

endpackage

// File: rtl/twi_sync_edge.sv
// Multi-flop synchronizer for one raw bus line, plus a history flop
// used to derive single-cycle rise/fall strobes. Idles high.
module twi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/twi_target_receiver.sv
// Write-only TWI target: matches its own address, ACKs it and every
// following data byte, and presents each received byte on rx_data.
module twi_target_receiver
    import twi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] own_addr,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  addr_match,
    output logic                  start_det,
    output logic                  stop_det,
    output logic                  busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    twi_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (scl_in),
        .level  (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    twi_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_in   (sda_in),
        .level  (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    twi_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       oe_q, oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       match_q, match_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;

    logic                  start_ev, stop_ev;
    logic [7:0]            shift_nxt;
    logic [ADDR_WIDTH-1:0] rx_addr;

    // SCL high now and in history: any simultaneous SCL edge wins
    assign start_ev  = sda_fall & scl_lvl & ~scl_rise;
    assign stop_ev   = sda_rise & scl_lvl & ~scl_rise;
    assign shift_nxt = {shift_q[6:0], sda_lvl};
    assign rx_addr   = ADDR_WIDTH'(shift_nxt[7:1]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        match_d    = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            oe_d    = OE_NACK;
            busy_d  = 1'b0;
        end else if (start_ev) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            oe_d    = OE_NACK;
            busy_d  = 1'b1;
            start_d = 1'b1;
        end else if (stop_ev) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            oe_d    = OE_NACK;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = shift_nxt;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (rx_addr == own_addr && !shift_nxt[0]) begin
                            state_d = ST_ADDR_ACK;
                            match_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_DATA: if (scl_rise) begin
                    shift_d = shift_nxt;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = ST_DATA_ACK;
                end
                // First SCL fall drives ACK, the second one ends the slot
                ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
                    if (oe_q == OE_NACK) begin
                        oe_d = OE_ACK;
                        if (state_q == ST_DATA_ACK) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        oe_d    = OE_NACK;
                        state_d = ST_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            oe_q       <= OE_NACK;
            rx_valid_q <= 1'b0;
            match_q    <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            oe_q       <= oe_d;
            rx_valid_q <= rx_valid_d;
            match_q    <= match_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe     = oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = match_q;
    assign start_det  = start_q;
    assign stop_det   = stop_q;
    assign busy       = busy_q;

endmodule
